// File: rtl/acq_sequencer_if.sv
// Record-stream / FIFO-write bundle between the timestamp stage, the run
// sequencer (master) and the downstream record FIFO (slave).
interface acq_sequencer_if #(
  parameter int REC_W = 41
) ();
  logic [REC_W-1:0] rec_data;
  logic             rec_ready;
  logic             fifo_full;
  logic             fifo_wr;
  logic [REC_W-1:0] fifo_din;

  modport master (input rec_data, rec_ready, fifo_full, output fifo_wr, fifo_din);
  modport slave  (output rec_data, rec_ready, fifo_full, input fifo_wr, fifo_din);
endinterface

// File: rtl/acq_sequencer.sv
// Run controller for the timestamp stage: IDLE/ARM/RUN/DRAIN sequencing, record
// gating into the FIFO, run statistics. ACQ_OVERFLOW_HALT_EN: first loss in RUN ends the run.
module acq_sequencer #(
  parameter int REC_W  = 41,
  parameter int LEN_W  = 48,
  parameter int LOST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              run_len_en,
  input  logic [LEN_W-1:0]  run_len,
  acq_sequencer_if.master   rec,
  output logic              tag_clear,
  output logic              tag_operate,
  output logic              running,
  output logic              done,
  output logic [31:0]       rec_count,
  output logic [LOST_W-1:0] lost_count,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_q, elapsed;
  logic               timed_q;
  logic               wr_q;
  logic [REC_W-1:0]   din_q;
  logic               in_rec, accept, lose, last_tick, halt;

  assign in_rec    = (state == RUN) || (state == DRAIN);
  assign accept    = in_rec && rec.rec_ready && !rec.fifo_full;
  assign lose      = in_rec && rec.rec_ready &&  rec.fifo_full;
  assign last_tick = timed_q && (elapsed == len_q - LEN_W'(1));

`ifdef ACQ_OVERFLOW_HALT_EN
  assign halt = lose;
`else
  assign halt = 1'b0;
`endif

  assign running     = (state != IDLE);
  assign rec.fifo_wr  = wr_q;
  assign rec.fifo_din = din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    tag_clear   = 1'b0;
    tag_operate = 1'b0;
    case (state)
      IDLE: begin
        tag_clear = 1'b1;
        if (start && !stop) state_nxt = ARM;
      end
      ARM: begin
        tag_clear = 1'b1;
        state_nxt = (stop || (timed_q && (len_q == '0))) ? DRAIN : RUN;
      end
      RUN: begin
        tag_operate = 1'b1;
        if (stop || last_tick || halt) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      timed_q    <= 1'b0;
      elapsed    <= '0;
      wr_q       <= 1'b0;
      din_q      <= '0;
      rec_count  <= '0;
      lost_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == DRAIN);
      wr_q <= accept;
      if (state == IDLE && start && !stop) begin
        len_q   <= run_len;
        timed_q <= run_len_en;
      end
      if (state == ARM) begin
        elapsed    <= '0;
        rec_count  <= '0;
        lost_count <= '0;
        overflow   <= 1'b0;
      end else if (state == RUN) begin
        elapsed <= elapsed + LEN_W'(1);
      end
      if (accept) begin
        din_q     <= rec.rec_data;
        rec_count <= rec_count + 32'd1;
      end
      // lost_count sticks at all-ones rather than wrapping
      if (lose) begin
        overflow <= 1'b1;
        if (lost_count != '1) lost_count <= lost_count + LOST_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: cycle table, directed runs, random runs
// checked against a run-level model, loss saturation and mid-run reset.
module tb_acq_sequencer;
  localparam int REC_W = 41, LEN_W = 48, LOST_W = 16;

  logic              clk = 1'b0;
  logic              rst_n, start, stop, run_len_en;
  logic [LEN_W-1:0]  run_len;
  logic              tag_clear, tag_operate, running, done, overflow;
  logic [31:0]       rec_count;
  logic [LOST_W-1:0] lost_count;

  acq_sequencer_if #(.REC_W(REC_W)) bus ();

  acq_sequencer #(.REC_W(REC_W), .LEN_W(LEN_W), .LOST_W(LOST_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .run_len_en(run_len_en), .run_len(run_len), .rec(bus),
    .tag_clear(tag_clear), .tag_operate(tag_operate), .running(running),
    .done(done), .rec_count(rec_count), .lost_count(lost_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic             start, stop, en;
    logic [LEN_W-1:0] len;
    logic             rdy, full;
    logic             clr, op, run, dn, wr;
    logic [31:0]      cnt;
  } vec_t;

  function automatic vec_t mk(bit s, bit p, bit e, int l, bit r, bit f,
                              bit c, bit o, bit u, bit d, bit w, int n);
    vec_t v;
    v.start = s; v.stop = p; v.en = e; v.len = LEN_W'(l); v.rdy = r; v.full = f;
    v.clr = c; v.op = o; v.run = u; v.dn = d; v.wr = w; v.cnt = 32'(n);
    return v;
  endfunction

  // One run: run-length arithmetic from the mode, stop and loss rules, then
  // expected FIFO contents and statistics from the per-cycle record pattern.
  task automatic run_case(input bit timed, input int len, input int stop_idx,
                          input bit arm_stop, input logic [31:0] rdy,
                          input logic [31:0] full, input int start_idx, input string nm);
    logic [REC_W-1:0] dat[32];
    logic [REC_W-1:0] expq[$], obsq[$];
    int L, elost, opc, dcnt, didx;
    for (int i = 0; i < 32; i++) dat[i] = {9'($urandom), 32'($urandom)};
    if (arm_stop || (timed && len == 0)) L = 0;
    else begin
      L = timed ? len : 1000;
      if (stop_idx >= 0 && stop_idx + 1 < L) L = stop_idx + 1;
`ifdef ACQ_OVERFLOW_HALT_EN
      for (int i = 0; i < L && i < 32; i++)
        if (rdy[i] && full[i]) begin L = i + 1; break; end
`endif
    end
    elost = 0;
    for (int i = 0; i <= L && i < 32; i++)
      if (rdy[i]) begin
        if (full[i]) elost++;
        else expq.push_back(dat[i]);
      end
    opc = 0; dcnt = 0; didx = -1;
    // IDLE: request
    start = 1'b1; stop = 1'b0; run_len_en = timed; run_len = LEN_W'(len);
    bus.rec_ready = 1'b0; bus.fifo_full = 1'b0;
    tick;
    // ARM: records offered here must be ignored
    chk({nm, " arm"}, {61'd0, tag_clear, tag_operate, running}, 64'b101);
    if (bus.fifo_wr) obsq.push_back(bus.fifo_din);
    start = 1'b0; stop = arm_stop; run_len = LEN_W'($urandom);
    bus.rec_ready = 1'b1; bus.rec_data = {9'($urandom), 32'($urandom)};
    tick;
    for (int i = 0; i < 32; i++) begin
      if (tag_operate) opc++;
      if (done) begin dcnt++; if (didx < 0) didx = i; end
      if (bus.fifo_wr) obsq.push_back(bus.fifo_din);
      bus.rec_ready = rdy[i]; bus.fifo_full = full[i]; bus.rec_data = dat[i];
      stop  = !arm_stop && (i == stop_idx);
      start = (i == start_idx) && (i <= L);
      tick;
    end
    start = 1'b0; stop = 1'b0; bus.rec_ready = 1'b0; bus.fifo_full = 1'b0;
    chk({nm, " operate cycles"}, 64'(opc), 64'(L));
    chk({nm, " done timing"}, {32'(dcnt), 32'(didx)}, {32'd1, 32'(L + 1)});
    chk({nm, " write count"}, 64'(obsq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < obsq.size(); i++)
      chk($sformatf("%s write %0d data", nm, i), 64'(obsq[i]), 64'(expq[i]));
    chk({nm, " rec_count"}, 64'(rec_count), 64'(expq.size()));
    chk({nm, " lost/overflow"}, {47'd0, overflow, lost_count}, {47'd0, elost > 0, 16'(elost)});
    chk({nm, " idle"}, {63'd0, running}, 64'd0);
  endtask

  vec_t tbl[18];

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; run_len_en = 1'b0; run_len = '0;
    bus.rec_data = '0; bus.rec_ready = 1'b0; bus.fifo_full = 1'b0;
    #12;
    chk("reset outputs", {59'd0, tag_clear, tag_operate, running, done, bus.fifo_wr}, 64'b10000);
    chk("reset stats", {15'd0, overflow, lost_count, rec_count}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;

    // cycle table: timed len 5, start+stop together, stop/records in IDLE, timed len 0
    tbl[0]  = mk(1,0,1,5, 0,0, 1,0,0,0,0, 0);
    tbl[1]  = mk(0,0,1,9, 1,0, 1,0,1,0,0, 0);
    tbl[2]  = mk(0,0,0,0, 0,0, 0,1,1,0,0, 0);
    tbl[3]  = mk(1,0,0,0, 0,0, 0,1,1,0,0, 0);
    tbl[4]  = mk(0,0,0,0, 0,0, 0,1,1,0,0, 0);
    tbl[5]  = mk(0,0,0,0, 0,0, 0,1,1,0,0, 0);
    tbl[6]  = mk(0,0,0,0, 1,0, 0,1,1,0,0, 0);
    tbl[7]  = mk(0,0,0,0, 1,0, 0,0,1,0,1, 1);
    tbl[8]  = mk(0,0,0,0, 0,0, 1,0,0,1,1, 2);
    tbl[9]  = mk(0,0,0,0, 0,0, 1,0,0,0,0, 2);
    tbl[10] = mk(1,1,1,3, 1,0, 1,0,0,0,0, 2);
    tbl[11] = mk(0,1,0,0, 0,0, 1,0,0,0,0, 2);
    tbl[12] = mk(0,0,0,0, 1,0, 1,0,0,0,0, 2);
    tbl[13] = mk(1,0,1,0, 0,0, 1,0,0,0,0, 2);
    tbl[14] = mk(0,0,0,0, 0,0, 1,0,1,0,0, 2);
    tbl[15] = mk(0,0,0,0, 0,0, 0,0,1,0,0, 0);
    tbl[16] = mk(0,0,0,0, 0,0, 1,0,0,1,0, 0);
    tbl[17] = mk(0,0,0,0, 0,0, 1,0,0,0,0, 0);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("vec %0d", k),
          {27'd0, tag_clear, tag_operate, running, done, bus.fifo_wr, rec_count},
          {27'd0, tbl[k].clr, tbl[k].op, tbl[k].run, tbl[k].dn, tbl[k].wr, tbl[k].cnt});
      start = tbl[k].start; stop = tbl[k].stop; run_len_en = tbl[k].en; run_len = tbl[k].len;
      bus.rec_ready = tbl[k].rdy; bus.fifo_full = tbl[k].full; bus.rec_data = 41'(k);
      tick;
    end
    start = 1'b0; stop = 1'b0; bus.rec_ready = 1'b0;
    tick;

    run_case(0, 0, 10, 0, 32'h0000_0C00, 32'h0, -1, "manual");
    run_case(0, 0, 8, 0, 32'h0000_000F, 32'h0000_0006, 5, "backpressure");
    run_case(1, 0, -1, 0, 32'h0000_00FF, 32'h0, -1, "len0");
    run_case(1, 10, -1, 1, 32'h0000_00FF, 32'h0, -1, "arm stop");
`ifdef ACQ_OVERFLOW_HALT_EN
    run_case(1, 100, -1, 0, 32'h0000_0008, 32'h0000_0008, -1, "halt");
`endif
    for (int n = 0; n < 40; n++) begin
      bit t;
      int sidx;
      t = 1'($urandom_range(0, 1));
      sidx = t ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1)
               : int'($urandom_range(0, 20));
      run_case(t, int'($urandom_range(0, 20)), sidx, $urandom_range(0, 15) == 0,
               $urandom, $urandom & $urandom, int'($urandom_range(0, 25)),
               $sformatf("rand %0d", n));
    end

`ifndef ACQ_OVERFLOW_HALT_EN
    // 70000 losses in one manual run
    start = 1'b1; run_len_en = 1'b0; tick;
    start = 1'b0; tick;
    bus.rec_ready = 1'b1; bus.fifo_full = 1'b1;
    repeat (70000) tick;
    stop = 1'b1; tick;
    stop = 1'b0; bus.rec_ready = 1'b0; bus.fifo_full = 1'b0; tick;
    chk("lost saturate", {15'd0, overflow, lost_count, rec_count}, {15'd0, 1'b1, 16'hFFFF, 32'd0});
`endif

    // reset in RUN with a write pending
    start = 1'b1; run_len_en = 1'b0; tick;
    start = 1'b0; tick;
    bus.rec_ready = 1'b1; bus.fifo_full = 1'b0; bus.rec_data = 41'h155;
    tick;
    chk("pre-reset write", {62'd0, bus.fifo_wr, tag_operate}, 64'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", {59'd0, tag_clear, tag_operate, running, done, bus.fifo_wr}, 64'b10000);
    chk("async reset stats", {15'd0, overflow, lost_count, rec_count}, 64'd0);
    bus.rec_ready = 1'b0;
    tick;
    chk("held reset", {62'd0, bus.fifo_wr, done}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;
    chk("post reset idle", {61'd0, done, running, bus.fifo_wr}, 64'd0);
    run_case(0, 0, 3, 0, 32'h0000_0005, 32'h0, -1, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Run controller for the pulse-registration/time-stamping stage.
- Sequences the stage's clear and operate inputs through a start / timed-or-manual run / drain cycle.
- Gates the stage's 41-bit record stream into the downstream record FIFO and keeps record and loss statistics for host readout.
- Sits between the host control registers and the timestamp stage / record FIFO.

Parameters:
- REC_W, 41, record width: [35:0] timestamp, [36] timer-zero marker, [40:37] channel mask.
- LEN_W, 48, width of the run-length and elapsed-cycle counters.
- LOST_W, 16, width of the saturating lost-record counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset; release is synchronous to clk.
- start  input  1  single-cycle run request.
- stop  input  1  single-cycle abort / stop request.
- run_len_en  input  1  1 = timed run of run_len cycles; 0 = run until stop.
- run_len  input  LEN_W  run length in clk cycles; sampled on the start cycle.
- rec_data  input  REC_W  record from the timestamp stage.
- rec_ready  input  1  rec_data valid this cycle.
- fifo_full  input  1  record FIFO cannot accept a write this cycle.
- tag_clear  output  1  drives the timestamp stage clear input.
- tag_operate  output  1  drives the timestamp stage operate input.
- fifo_wr  output  1  FIFO write strobe.
- fifo_din  output  REC_W  FIFO write data.
- running  output  1  high in ARM, RUN and DRAIN.
- done  output  1  one-cycle pulse when a run finishes.
- rec_count  output  32  records written to the FIFO in the current/last run.
- lost_count  output  LOST_W  records dropped because of fifo_full.
- overflow  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; tag_clear = 1; all other outputs 0.
  - Counters 0; the latched run length is 0.
- States: IDLE, ARM, RUN, DRAIN.
- IDLE:
  - tag_clear = 1, tag_operate = 0.
  - start && !stop: latch run_len and run_len_en, go to ARM.
  - start && stop in the same cycle: stay IDLE.
- ARM (exactly 1 cycle):
  - tag_clear = 1.
  - Clears rec_count, lost_count, overflow and the elapsed counter.
  - Next state is RUN, or DRAIN if the latched mode is timed with length 0.
- RUN:
  - tag_clear = 0, tag_operate = 1.
  - The elapsed counter increments each cycle.
  - Goes to DRAIN when stop = 1, or when timed and elapsed == latched_len-1. A timed run therefore holds operate high for exactly latched_len cycles.
- DRAIN (exactly 1 cycle):
  - tag_clear = 0, tag_operate = 0.
  - Accepts the last record that the timestamp stage registered one cycle after RUN ended.
  - Then goes to IDLE and asserts done for 1 cycle, coincident with the first IDLE cycle.
- Record path (evaluated in RUN and DRAIN only; rec_ready is ignored in IDLE and ARM):
  - rec_ready && !fifo_full: next cycle fifo_wr = 1 and fifo_din = rec_data, a registered 1-cycle latency; rec_count increments.
  - rec_ready && fifo_full: no write; lost_count increments and saturates at all-ones.
  - fifo_din holds its last value when fifo_wr = 0.
  - rec_count wraps modulo 2^32.
- Requests outside IDLE:
  - start is ignored in ARM, RUN and DRAIN.
  - stop in ARM still completes ARM, then goes to DRAIN instead of RUN.
  - stop in DRAIN or IDLE has no effect.
- run_len changes after the start cycle have no effect on the current run.
- Statistics hold their values in IDLE until the next ARM.
- rst_n asserted mid-run: immediate return to reset values. A pending fifo_wr is squashed and done is not pulsed.

Optional Feature:
- Macro: ACQ_OVERFLOW_HALT_EN.
- Defined:
  - The first lost record in RUN sets overflow (sticky until the next ARM) and forces RUN to DRAIN on the following cycle.
  - A loss in DRAIN sets overflow only.
- Undefined:
  - Losses only increment lost_count; the run continues.
  - overflow still sets on the first loss, but never ends the run.

Test Plan:
1. Timed run: run_len_en=1, run_len=5, start pulse. Expect tag_clear high through ARM, then tag_operate high for exactly 5 cycles, DRAIN 1 cycle, done pulse, running low 8 cycles after start.
2. Manual run: run_len_en=0, start, then stop 10 cycles later, with a rec_ready in the last RUN cycle and another in DRAIN. Expect both written, fifo_wr 1 cycle after each, rec_count=2, done after DRAIN.
3. FIFO backpressure without the macro: 4 records with fifo_full=1 on records 2 and 3. Expect 2 writes, lost_count=2, overflow=1, run continues to stop.
4. FIFO backpressure with ACQ_OVERFLOW_HALT_EN: a loss in RUN cycle 3 of a 100-cycle run. Expect DRAIN in the next cycle, done, overflow=1, lost_count=1.
5. Boundaries:
   - run_len_en=1, run_len=0: ARM→DRAIN, tag_operate never high, done pulsed.
   - start and stop in the same cycle in IDLE: nothing happens.
   - 70000 losses: lost_count saturates at 16'hFFFF.
6. rst_n dropped in RUN with a write pending: all outputs at reset values immediately, no fifo_wr, no done. A new start after release runs normally with counters re-cleared.
